calc_op_sequencer: RTL

Sequences the calculator datapath of the 8-bit RISC processor. It edge-detects the operator buttons and encodes them with fixed priority into the shared 3-bit opcode. It then issues one operation at a time to the ALU with a start/done handshake, writes the result back to the accumulator and keeps a one-deep previous-result history. It sits between the synchronized push-button inputs and the ALU/register/display logic.

---
 rtl/calc_pkg.sv | 17 +
 rtl/btn_edge_prio.sv | 40 ++++
 rtl/calc_op_sequencer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared opcode constants and sequencer state encoding for the calculator datapath.
package calc_pkg;
    localparam logic [2:0] OP_ADD   = 3'b000;
    localparam logic [2:0] OP_SUB   = 3'b001;
    localparam logic [2:0] OP_MULT  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_PREV  = 3'b100;
    localparam logic [2:0] OP_CLEAR = 3'b101;
    localparam logic [2:0] OP_SHOW  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_WB    = 2'd3
    } state_e;
endpackage

// File: rtl/btn_edge_prio.sv
// Rising-edge detection of the operator buttons with fixed-priority encoding
// (add > sub > mult > div > prev) into a single-cycle event and opcode.
module btn_edge_prio
    import calc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_add_i,
    input  logic       btn_sub_i,
    input  logic       btn_mult_i,
    input  logic       btn_div_i,
    input  logic       btn_prev_i,
    output logic       valid_o,
    output logic [2:0] op_o
);
    logic [4:0] lvl;
    logic [4:0] lvl_q;
    logic [4:0] rise;

    assign lvl  = {btn_prev_i, btn_div_i, btn_mult_i, btn_sub_i, btn_add_i};
    assign rise = lvl & ~lvl_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_q <= '0;
        end else begin
            lvl_q <= lvl;
        end
    end

    always_comb begin
        valid_o = |rise;
        op_o    = OP_SHOW;
        if (rise[0])      op_o = OP_ADD;
        else if (rise[1]) op_o = OP_SUB;
        else if (rise[2]) op_o = OP_MULT;
        else if (rise[3]) op_o = OP_DIV;
        else if (rise[4]) op_o = OP_PREV;
    end
endmodule

// File: rtl/calc_op_sequencer.sv
// Issues one ALU operation at a time from button events, writes the result back
// to the accumulator and keeps a one-deep previous-result history.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_add,
    input  logic              btn_sub,
    input  logic              btn_mult,
    input  logic              btn_div,
    input  logic              btn_prev,
    input  logic              clr_n,
    input  logic [DATA_W-1:0] sw_operand,
    output logic              alu_start,
    output logic [2:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_done,
    input  logic              alu_err,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] acc,
    output logic [DATA_W-1:0] prev_acc,
    output logic [2:0]        last_op,
    output logic              busy,
    output logic              err
);
    localparam logic [7:0] TMO = 8'(TIMEOUT);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d, prev_q, prev_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]        op_q, op_d, last_q, last_d;
    logic              err_q, err_d, res_err_q, res_err_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              ev_valid;
    logic [2:0]        ev_op;

    btn_edge_prio u_btn (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_add_i (btn_add),
        .btn_sub_i (btn_sub),
        .btn_mult_i(btn_mult),
        .btn_div_i (btn_div),
        .btn_prev_i(btn_prev),
        .valid_o   (ev_valid),
        .op_o      (ev_op)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            prev_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            op_q      <= OP_SHOW;
            last_q    <= OP_SHOW;
            err_q     <= 1'b0;
            res_err_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            prev_q    <= prev_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            op_q      <= op_d;
            last_q    <= last_d;
            err_q     <= err_d;
            res_err_q <= res_err_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        prev_d    = prev_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        op_d      = op_q;
        last_d    = last_q;
        err_d     = err_q;
        res_err_d = res_err_q;
        cnt_d     = cnt_q;
        if (!clr_n) begin
            // Clear wins over everything, including a result arriving this cycle.
            state_d = ST_IDLE;
            acc_d   = '0;
            prev_d  = '0;
            err_d   = 1'b0;
            last_d  = OP_CLEAR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ev_valid) begin
                        if (ev_op == OP_PREV) begin
                            acc_d  = prev_q;
                            prev_d = acc_q;
                            last_d = OP_PREV;
                        end else begin
                            state_d = ST_ISSUE;
                            a_d     = acc_q;
                            b_d     = sw_operand;
                            op_d    = ev_op;
                            last_d  = ev_op;
                        end
                    end
                end
                ST_ISSUE: begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    // Capture here: the ALU only guarantees the result alongside done.
                    if (alu_done) begin
                        res_d     = alu_result;
                        res_err_d = alu_err;
                        state_d   = ST_WB;
                    end else if (cnt_q == TMO) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_WB: begin
                    if (res_err_q) begin
                        err_d = 1'b1;
                    end else begin
                        prev_d = acc_q;
                        acc_d  = res_q;
                        err_d  = 1'b0;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign alu_start = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign alu_op    = op_q;
    assign alu_a     = a_q;
    assign alu_b     = b_q;
    assign acc       = acc_q;
    assign prev_acc  = prev_q;
    assign last_op   = last_q;
    assign err       = err_q;
endmodule
